// File: rtl/fft_frame_loader_if.sv
// Byte-stream handshake between an upstream sample source and the FFT frame loader.
interface fft_frame_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_sof;
    logic       in_ready;

    modport master (output in_data, output in_valid, output in_sof, input in_ready);
    modport slave  (input in_data, input in_valid, input in_sof, output in_ready);
endinterface

// File: rtl/fft_frame_loader.sv
// Byte-serial front end for the 8-point FFT core: gathers 16 bytes into a shadow
// buffer, commits them to held parallel registers, and tracks the core latency.
//
// state (independent pair)  | meaning
// FILL  (shadow_full=0)     | shadow buffer accepting bytes
// FULL  (shadow_full=1)     | frame complete, waiting for core to go idle
// IDLE  (busy=0)            | no frame in the core pipeline
// BUSY  (busy=1)            | committed frame travelling through the core
module fft_frame_loader #(
    parameter int PIPE_LATENCY = 3,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    fft_frame_loader_if.slave  s,
    output logic [7:0]         x0_re,
    output logic [7:0]         x0_im,
    output logic [7:0]         x1_re,
    output logic [7:0]         x1_im,
    output logic [7:0]         x2_re,
    output logic [7:0]         x2_im,
    output logic [7:0]         x3_re,
    output logic [7:0]         x3_im,
    output logic [7:0]         x4_re,
    output logic [7:0]         x4_im,
    output logic [7:0]         x5_re,
    output logic [7:0]         x5_im,
    output logic [7:0]         x6_re,
    output logic [7:0]         x6_im,
    output logic [7:0]         x7_re,
    output logic [7:0]         x7_im,
    output logic               frame_valid,
    output logic               result_valid,
    output logic               busy
);

    logic [7:0]       shadow_q [16];
    logic [7:0]       shadow_d [16];
    logic [7:0]       x_q [16];
    logic [7:0]       x_d [16];
    logic [3:0]       idx_q, idx_d;
    logic             full_q, full_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fv_q, fv_d;
    logic             rv_q, rv_d;
    logic             accept;

    // Ready depends only on the buffer state so upstream never sees a combinational loop.
    assign s.in_ready = ~full_q;
    assign accept     = s.in_valid & ~full_q;

    // Next-state: byte capture, commit to output registers, and latency countdown.
    always_comb begin
        shadow_d = shadow_q;
        x_d      = x_q;
        idx_d    = idx_q;
        full_d   = full_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        fv_d     = 1'b0;
        rv_d     = 1'b0;

        if (accept) begin
            if (s.in_sof) begin
                // Start-of-frame resynchronises, dropping any partial frame.
                shadow_d[0] = s.in_data;
                idx_d       = 4'd1;
            end else begin
                shadow_d[idx_q] = s.in_data;
                if (idx_q == 4'd15) begin
                    full_d = 1'b1;
                    idx_d  = 4'd0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
        end

        if (busy_q) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                rv_d   = 1'b1;
            end
        end

        // Commit only when the core is idle; accept cannot coincide since full blocks it.
        if (full_q && !busy_q) begin
            x_d    = shadow_q;
            full_d = 1'b0;
            fv_d   = 1'b1;
            busy_d = 1'b1;
            cnt_d  = CNT_W'(PIPE_LATENCY);
        end
    end

    // State registers with synchronous reset; reset also cancels any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                shadow_q[i] <= 8'd0;
                x_q[i]      <= 8'd0;
            end
            idx_q  <= 4'd0;
            full_q <= 1'b0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            fv_q   <= 1'b0;
            rv_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            x_q      <= x_d;
            idx_q    <= idx_d;
            full_q   <= full_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            fv_q     <= fv_d;
            rv_q     <= rv_d;
        end
    end

    assign x0_re = x_q[0];
    assign x0_im = x_q[1];
    assign x1_re = x_q[2];
    assign x1_im = x_q[3];
    assign x2_re = x_q[4];
    assign x2_im = x_q[5];
    assign x3_re = x_q[6];
    assign x3_im = x_q[7];
    assign x4_re = x_q[8];
    assign x4_im = x_q[9];
    assign x5_re = x_q[10];
    assign x5_im = x_q[11];
    assign x6_re = x_q[12];
    assign x6_im = x_q[13];
    assign x7_re = x_q[14];
    assign x7_im = x_q[15];

    assign frame_valid  = fv_q;
    assign result_valid = rv_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: one instance at latency 3, one at latency 20.
module tb_fft_frame_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [7:0] d_data = 8'hEE;
    logic       d_valid = 1'b0;
    logic       d_sof = 1'b0;
    logic       sel = 1'b0;

    fft_frame_loader_if if_a ();
    fft_frame_loader_if if_b ();

    assign if_a.in_data  = d_data;
    assign if_a.in_valid = d_valid & ~sel;
    assign if_a.in_sof   = d_sof;
    assign if_b.in_data  = d_data;
    assign if_b.in_valid = d_valid & sel;
    assign if_b.in_sof   = d_sof;

    logic [7:0] xa [16];
    logic [7:0] xb [16];
    logic fva, rva, busya, fvb, rvb, busyb;

    fft_frame_loader #(.PIPE_LATENCY(3), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .s(if_a),
        .x0_re(xa[0]),  .x0_im(xa[1]),  .x1_re(xa[2]),  .x1_im(xa[3]),
        .x2_re(xa[4]),  .x2_im(xa[5]),  .x3_re(xa[6]),  .x3_im(xa[7]),
        .x4_re(xa[8]),  .x4_im(xa[9]),  .x5_re(xa[10]), .x5_im(xa[11]),
        .x6_re(xa[12]), .x6_im(xa[13]), .x7_re(xa[14]), .x7_im(xa[15]),
        .frame_valid(fva), .result_valid(rva), .busy(busya)
    );

    fft_frame_loader #(.PIPE_LATENCY(20), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .s(if_b),
        .x0_re(xb[0]),  .x0_im(xb[1]),  .x1_re(xb[2]),  .x1_im(xb[3]),
        .x2_re(xb[4]),  .x2_im(xb[5]),  .x3_re(xb[6]),  .x3_im(xb[7]),
        .x4_re(xb[8]),  .x4_im(xb[9]),  .x5_re(xb[10]), .x5_im(xb[11]),
        .x6_re(xb[12]), .x6_im(xb[13]), .x7_re(xb[14]), .x7_im(xb[15]),
        .frame_valid(fvb), .result_valid(rvb), .busy(busyb)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack(input logic [7:0] a [16]);
        logic [127:0] p;
        for (int i = 0; i < 16; i++) p[8*i +: 8] = a[i];
        return p;
    endfunction

    // Scoreboard: frames pushed as the model sees the 16th byte accepted.
    logic [127:0] q_a [$];
    logic [127:0] q_b [$];
    logic [127:0] mdl_buf [2];
    int           mdl_idx [2];
    logic [127:0] prev_x [2];
    int fv_cnt [2];
    int last_fv [2];
    int prev_fv [2];
    int rv_due [2];
    int cyc = 0;

    task automatic model_accept(input int d, input logic [7:0] data, input logic sof);
        if (sof) mdl_idx[d] = 0;
        mdl_buf[d][8*mdl_idx[d] +: 8] = data;
        mdl_idx[d]++;
        if (mdl_idx[d] == 16) begin
            if (d == 0) q_a.push_back(mdl_buf[d]);
            else        q_b.push_back(mdl_buf[d]);
            mdl_idx[d] = 0;
        end
    endtask

    task automatic mon(input int d);
        logic [127:0] x;
        logic [127:0] e;
        logic fv, rv;
        int lat;
        x   = (d == 0) ? pack(xa) : pack(xb);
        fv  = (d == 0) ? fva : fvb;
        rv  = (d == 0) ? rva : rvb;
        lat = (d == 0) ? 3 : 20;
        if (rst) begin
            chk("reset_x", x, 128'd0);
            chk("reset_pulses", {126'd0, fv, rv}, 128'd0);
            rv_due[d] = -1;
            prev_x[d] = x;
            return;
        end
        chk("fv_rv_overlap", {127'd0, fv & rv}, 128'd0);
        if (rv) begin
            chk("result_timing", 128'(cyc), 128'(rv_due[d]));
            rv_due[d] = -1;
        end else if (rv_due[d] >= 0 && cyc >= rv_due[d]) begin
            chk("result_missing", 128'd0, 128'd1);
            rv_due[d] = -1;
        end
        if (fv) begin
            fv_cnt[d]++;
            prev_fv[d] = last_fv[d];
            last_fv[d] = cyc;
            rv_due[d]  = cyc + lat;
            if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
                chk("unexpected_frame", x, 128'd0 - 1);
            end else begin
                e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
                chk("frame_data", x, e);
            end
        end else begin
            chk("x_hold", x, prev_x[d]);
        end
        prev_x[d] = x;
    endtask

    always @(posedge clk) begin
        #2;
        cyc++;
        mon(0);
        mon(1);
    end

    function automatic logic cur_ready();
        return sel ? if_b.in_ready : if_a.in_ready;
    endfunction

    task automatic idle();
        @(negedge clk);
        d_valid = 1'b0;
        d_sof   = 1'b0;
        d_data  = 8'hEE;
    endtask

    // Presents one byte and holds it until accepted; returns just after the accept edge.
    task automatic send_byte(input logic [7:0] data, input logic sof);
        int n = 0;
        logic r;
        @(negedge clk);
        d_data = data; d_sof = sof; d_valid = 1'b1;
        forever begin
            r = cur_ready();
            @(posedge clk);
            if (r) begin
                model_accept(sel ? 1 : 0, data, sof);
                return;
            end
            n++;
            if (n > 100) begin
                chk("accept_timeout", 128'd0, 128'd1);
                d_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [127:0] data, input logic first_sof, input logic gap);
        for (int i = 0; i < 16; i++) begin
            if (gap) idle();
            send_byte(data[8*i +: 8], first_sof && (i == 0));
        end
    endtask

    task automatic wait_frames(input int d, input int target);
        int n = 0;
        while (fv_cnt[d] < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("frame_count", 128'(fv_cnt[d]), 128'(target));
    endtask

    typedef struct {
        logic [127:0] data;
        logic [7:0]   x0_re, x0_im, x3_re, x7_im;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int n0;
        int stall;
        logic r;

        vecs[0] = '{128'h10, 8'h10, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{128'h0F0E0D0C0B0A09080706050403020100, 8'h00, 8'h01, 8'h06, 8'h0F};
        vecs[2] = '{{16{8'h55}}, 8'h55, 8'h55, 8'h55, 8'h55};
        vecs[3] = '{128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 8'h0F, 8'h1E, 8'h69, 8'hF0};
        for (int d = 0; d < 2; d++) begin
            mdl_idx[d] = 0; fv_cnt[d] = 0; last_fv[d] = 0; prev_fv[d] = 0; rv_due[d] = -1;
        end

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", {126'd0, if_a.in_ready, if_b.in_ready}, 128'd3);
        chk("reset_busy",  {126'd0, busya, busyb}, 128'd0);

        // Table-driven frames, continuous valid: commit one cycle after the 16th accept.
        for (int v = 0; v < 4; v++) begin
            n0 = fv_cnt[0];
            send_frame(vecs[v].data, 1'b1, 1'b0);
            @(negedge clk);
            r = if_a.in_ready;
            d_valid = 1'b0;
            chk("ready_low_after_16th", {127'd0, r}, 128'd0);
            chk("fv_not_early", {127'd0, fva}, 128'd0);
            @(negedge clk);
            chk("fv_pulse", {127'd0, fva}, 128'd1);
            chk("ready_back", {127'd0, if_a.in_ready}, 128'd1);
            chk("x0_re", 128'(xa[0]), 128'(vecs[v].x0_re));
            chk("x0_im", 128'(xa[1]), 128'(vecs[v].x0_im));
            chk("x3_re", 128'(xa[6]), 128'(vecs[v].x3_re));
            chk("x7_im", 128'(xa[15]), 128'(vecs[v].x7_im));
            repeat (5) @(negedge clk);
            chk("one_frame", 128'(fv_cnt[0]), 128'(n0 + 1));
            chk("busy_clear", {127'd0, busya}, 128'd0);
        end

        // SOF resync: partial frame of 0x11 discarded.
        n0 = fv_cnt[0];
        for (int i = 0; i < 5; i++) send_byte(8'h11, i == 0);
        send_byte(8'hAA, 1'b1);
        for (int i = 0; i < 15; i++) send_byte(8'h22, 1'b0);
        idle();
        wait_frames(0, n0 + 1);
        chk("resync_x", pack(xa), {{15{8'h22}}, 8'hAA});
        repeat (8) @(negedge clk);
        chk("resync_single", 128'(fv_cnt[0]), 128'(n0 + 1));

        // Gapped input: valid every other cycle.
        n0 = fv_cnt[0];
        send_frame(128'h0123456789ABCDEFFEDCBA9876543210, 1'b1, 1'b1);
        idle();
        wait_frames(0, n0 + 1);
        repeat (8) @(negedge clk);
        chk("gapped_single", 128'(fv_cnt[0]), 128'(n0 + 1));

        // Reset while the committed frame is in flight (cnt=2), with a byte presented.
        n0 = fv_cnt[0];
        send_frame({16{8'h55}}, 1'b1, 1'b0);
        idle();
        wait_frames(0, n0 + 1);
        @(negedge clk);
        rst = 1'b1; d_valid = 1'b1; d_data = 8'h99; d_sof = 1'b0;
        @(negedge clk);
        rst = 1'b0; d_valid = 1'b0;
        for (int d = 0; d < 2; d++) mdl_idx[d] = 0;
        q_a.delete(); q_b.delete();
        chk("rst_x", pack(xa), 128'd0);
        chk("rst_busy", {127'd0, busya}, 128'd0);
        chk("rst_ready", {127'd0, if_a.in_ready}, 128'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rv_suppressed", {127'd0, rva}, 128'd0);
        end
        n0 = fv_cnt[0];
        send_frame(128'h33333333333333333333333333333333 + 128'h0F, 1'b0, 1'b0);
        idle();
        wait_frames(0, n0 + 1);

        // Back-to-back at latency 20: second frame stalls until the core drains.
        sel = 1'b1;
        n0 = fv_cnt[1];
        send_frame(128'h1F1E1D1C1B1A19181716151413121110, 1'b1, 1'b0);
        send_frame(128'h2F2E2D2C2B2A29282726252423222120, 1'b1, 1'b0);
        idle();
        stall = 0;
        while (!if_b.in_ready && stall < 50) begin
            stall++;
            @(negedge clk);
        end
        chk("b2b_stall", 128'(stall), 128'd5);
        wait_frames(1, n0 + 2);
        chk("b2b_gap", 128'(last_fv[1] - prev_fv[1]), 128'd21);
        repeat (25) @(negedge clk);
        chk("b2b_queue_empty", 128'(q_b.size()), 128'd0);
        chk("a_queue_empty", 128'(q_a.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Byte-serial front end for the 8-point radix-2 FFT core.
- Collects 16 bytes per frame (real/imag of eight 8-bit unsigned samples) into a shadow buffer, then commits them to stable parallel output registers that drive the core's x0_re..x7_im inputs.
- Tracks the core's fixed pipeline latency and pulses result_valid when the core outputs correspond to the committed frame.
- At most one frame is in flight in the core.

Parameters:
PIPE_LATENCY, 3, cycles from input-register update to valid FFT outputs (one register per butterfly stage, three stages); legal range 1..255
CNT_W, 8, width of latency counter; must hold PIPE_LATENCY

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
in_data  input  8  sample byte
in_valid  input  1  in_data valid this cycle
in_sof  input  1  start-of-frame marker, qualified by in_valid
in_ready  output  1  loader can accept a byte this cycle
x0_re..x7_re, x0_im..x7_im  output  8 each  committed frame, held stable between commits, to FFT core
frame_valid  output  1  one-cycle pulse: new frame on x* outputs this cycle
result_valid  output  1  one-cycle pulse: FFT outputs this cycle belong to last committed frame
busy  output  1  frame in flight in FFT pipeline

Behaviour:
- Byte order within frame: x0_re, x0_im, x1_re, x1_im, ..., x7_re, x7_im (index 0..15).
- Accept occurs at a rising edge where in_valid & in_ready are both 1.
- in_ready = !shadow_full. It is combinational from state only and never depends on in_valid.
- Accept with in_sof=0: shadow[idx] <= in_data, idx <= idx+1.
- Accept with in_sof=1: shadow[0] <= in_data, idx <= 1. Any partial frame is discarded. sof wins even when idx=15.
- in_sof is ignored when no accept occurs.
- Accept at idx=15 (sof=0): shadow_full <= 1, idx <= 0.
- Commit rule: at any edge where shadow_full=1 and busy=0:
  - all 16 x* registers <= shadow contents
  - shadow_full <= 0
  - frame_valid <= 1 for exactly one cycle
  - busy <= 1
  - cnt <= PIPE_LATENCY
- Earliest commit is the edge after the 16th accept. Result: in_ready is low for at least one cycle per frame.
- Latency tracking:
  - While busy, cnt decrements each edge.
  - At the edge where cnt goes 1->0: busy <= 0 and result_valid <= 1 for one cycle.
  - For a commit at edge C, result_valid is high in the cycle following edge C+PIPE_LATENCY.
  - The next commit is possible at edge C+PIPE_LATENCY+1 at the earliest.
- While busy, the shadow buffer keeps filling. If it fills before busy clears, in_ready stays low until the commit edge. No bytes are lost; upstream stalls.
- x* outputs change only at commit edges and reset. They are otherwise held.
- frame_valid and result_valid are registered outputs. Both are high simultaneously only when PIPE_LATENCY elapses exactly at a commit, which the commit rule forbids. Therefore they are never both high.
- Reset (any cycle, including mid-frame or mid-latency):
  - idx=0, shadow_full=0, shadow=0, x*=0, cnt=0, busy=0, frame_valid=0, result_valid=0.
  - in_ready=1 in the cycle after reset.
  - The in-flight frame's result_valid is suppressed.
  - Bytes presented during reset are not accepted.
- State summary:
  - FILL: shadow_full=0.
  - FULL: shadow_full=1, waiting for busy=0.
  - These combine independently with IDLE/BUSY of the latency counter.

Test Plan:
- Impulse: 16 bytes, sof on first, x0_re=0x10, rest 0x00, in_valid continuous. Required: x0_re=0x10, other x*=0 from commit cycle; frame_valid one pulse one cycle after 16th accept; result_valid exactly 3 cycles after frame_valid; in_ready low exactly one cycle.
- Ramp ordering: bytes 0x00..0x0F. Required: x0_re=0x00, x0_im=0x01, x3_re=0x06, x7_im=0x0F.
- Back-to-back with PIPE_LATENCY=20: 32 continuous bytes. Required: second frame's 16th byte accepted, then in_ready held low until busy clears; second commit at edge C1+21; no byte lost; first frame's x* stable for 21 cycles.
- SOF resync: 5 bytes 0x11, then sof byte 0xAA, then 15 bytes 0x22. Required: one commit only, with x0_re=0xAA and all others 0x22.
- Reset mid-latency: commit frame of 0x55 bytes, assert rst for 1 cycle at cnt=2. Required: x*=0, busy=0, no result_valid pulse; a subsequent 16-byte frame commits normally.
- Gapped input: in_valid toggled every other cycle over a full frame. Required: commit after 16th accept only; frame_valid count = 1.
